// File: rtl/word_aligner_9b_pkg.sv
// Shared calibration receive-path definitions: aligner state encoding, the
// calibration sync code word and the code word width.
package word_aligner_9b_pkg;

  localparam int CAL_CODE_W = 9;

  localparam logic [CAL_CODE_W-1:0] CAL_SYNC_WORD = 9'h1C7;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } cal_state_e;

endpackage

// File: rtl/word_aligner_9b.sv
// Serial-to-parallel word aligner: hunts for a repeated sync word, confirms it
// at the aligned boundary, then strobes out aligned 9-bit code words.
module word_aligner_9b
  import word_aligner_9b_pkg::*;
#(
  parameter logic [CAL_CODE_W-1:0] SYNC_WORD = CAL_SYNC_WORD,
  parameter int                    N_CONFIRM = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  realign,
  output logic [CAL_CODE_W-1:0] code_out,
  output logic                  code_valid,
  output logic                  is_sync,
  output logic                  locked,
  output logic                  align_err
);

  localparam logic [2:0] N_CONF_L = 3'(N_CONFIRM);

  cal_state_e            state_q, state_d;
  logic [CAL_CODE_W-1:0] win_q, win_d;
  logic [3:0]            fill_q, fill_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [2:0]            conf_cnt_q, conf_cnt_d;
  logic [CAL_CODE_W-1:0] code_out_q, code_out_d;
  logic                  code_valid_q, code_valid_d;
  logic                  is_sync_q, is_sync_d;
  logic                  locked_q, locked_d;
  logic                  align_err_q, align_err_d;

  logic [CAL_CODE_W-1:0] nxt;
  logic                  sync_hit;
  logic                  boundary;
  logic [2:0]            conf_inc;

  assign nxt      = {win_q[CAL_CODE_W-2:0], bit_in};
  assign sync_hit = (nxt == SYNC_WORD);
  assign boundary = bit_valid && (bit_cnt_q == 4'd8);
  assign conf_inc = conf_cnt_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      win_q        <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      conf_cnt_q   <= '0;
      code_out_q   <= '0;
      code_valid_q <= 1'b0;
      is_sync_q    <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      conf_cnt_q   <= conf_cnt_d;
      code_out_q   <= code_out_d;
      code_valid_q <= code_valid_d;
      is_sync_q    <= is_sync_d;
      locked_q     <= locked_d;
      align_err_q  <= align_err_d;
    end
  end

  // Next state and counters; a realign discards the bit offered with it.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    conf_cnt_d = conf_cnt_q;
    if (realign) begin
      state_d    = ST_HUNT;
      fill_d     = '0;
      bit_cnt_d  = '0;
      conf_cnt_d = '0;
    end else if (bit_valid) begin
      win_d     = nxt;
      fill_d    = (fill_q >= 4'd9) ? 4'd9 : fill_q + 4'd1;
      bit_cnt_d = (bit_cnt_q == 4'd8) ? 4'd0 : bit_cnt_q + 4'd1;
      case (state_q)
        ST_HUNT: begin
          if ((fill_q >= 4'd8) && sync_hit) begin
            bit_cnt_d  = '0;
            conf_cnt_d = '0;
            state_d    = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (bit_cnt_q == 4'd8) begin
            if (sync_hit) begin
              conf_cnt_d = conf_inc;
              if (conf_inc == N_CONF_L) state_d = ST_LOCKED;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_LOCKED: ;
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    code_out_d   = code_out_q;
    code_valid_d = 1'b0;
    is_sync_d    = is_sync_q;
    align_err_d  = 1'b0;
    locked_d     = (state_d == ST_LOCKED);
    if (!realign && boundary) begin
      if (state_q == ST_LOCKED) begin
        code_out_d   = nxt;
        code_valid_d = 1'b1;
        is_sync_d    = sync_hit;
      end else if (state_q == ST_CONFIRM && !sync_hit) begin
        align_err_d = 1'b1;
      end
    end
  end

  assign code_out   = code_out_q;
  assign code_valid = code_valid_q;
  assign is_sync    = is_sync_q;
  assign locked     = locked_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_word_aligner_9b.sv
// Scoreboard bench for word_aligner_9b: expected code words are queued as the
// stimulus is driven and compared whenever the aligner strobes code_valid.
module tb_word_aligner_9b;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       realign;
  logic [8:0] code_out;
  logic       code_valid;
  logic       is_sync;
  logic       locked;
  logic       align_err;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         err_cnt = 0;
  logic [9:0] exp_q[$];

  word_aligner_9b dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .realign    (realign),
    .code_out   (code_out),
    .code_valid (code_valid),
    .is_sync    (is_sync),
    .locked     (locked),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (align_err) err_cnt++;
    if (code_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {23'd0, code_out}, 32'h0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("code_out", {23'd0, code_out}, {23'd0, e[8:0]});
        chk("is_sync", {31'd0, is_sync}, {31'd0, e[9]});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] w, input int gap_at, input int gap_len);
    for (int i = 8; i >= 0; i--) begin
      if ((8 - i) == gap_at) idle(gap_len);
      send_bit(w[i]);
    end
  endtask

  task automatic push_exp(input logic [8:0] w);
    exp_q.push_back({(w == 9'h1C7), w});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code_out"}, {23'd0, code_out}, 32'h0);
    chk({tag, "_code_valid"}, {31'd0, code_valid}, 32'h0);
    chk({tag, "_is_sync"}, {31'd0, is_sync}, 32'h0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'h0);
    chk({tag, "_align_err"}, {31'd0, align_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    realign   = 1'b0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;

    // Random lead-in, three syncs lock, then a data word.
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    send_word(9'h1C7, -1, 0);
    send_word(9'h1C7, -1, 0);
    chk("lock_after_2", {31'd0, locked}, 32'h0);
    send_word(9'h1C7, -1, 0);
    chk("lock_after_3", {31'd0, locked}, 32'h1);
    push_exp(9'h0A5);
    send_word(9'h0A5, -1, 0);
    chk("cv_latency_0A5", {31'd0, code_valid}, 32'h1);
    idle(2);
    chk("hold_0A5", {23'd0, code_out}, 32'h0A5);

    // Reset while locked; a following sync must not strobe.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_all_zero("mid_rst");
    send_word(9'h1C7, -1, 0);
    chk("no_lock_after_rst", {31'd0, locked}, 32'h0);

    // Sync then a near-miss word: confirmation fails once, then relock.
    e0 = err_cnt;
    send_word(9'h1C6, -1, 0);
    chk("align_err_pulse", {31'd0, align_err}, 32'h1);
    chk("unlocked_after_err", {31'd0, locked}, 32'h0);
    send_word(9'h1C7, -1, 0);
    send_word(9'h1C7, -1, 0);
    send_word(9'h1C7, -1, 0);
    chk("relock_after_err", {31'd0, locked}, 32'h1);
    chk("err_count_once", 32'(err_cnt - e0), 32'h1);

    // Locked words with a gap in the middle of the second one.
    push_exp(9'h1C7);
    send_word(9'h1C7, -1, 0);
    chk("cv_latency_sync", {31'd0, code_valid}, 32'h1);
    push_exp(9'h123);
    send_word(9'h123, $urandom_range(1, 8), 5);
    chk("cv_latency_123", {31'd0, code_valid}, 32'h1);
    idle(3);
    chk("hold_123", {23'd0, code_out}, 32'h123);

    // Realign together with a valid bit.
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    realign   = 1'b1;
    idle(1);
    realign   = 1'b0;
    bit_valid = 1'b0;
    chk("realign_unlock", {31'd0, locked}, 32'h0);
    chk("realign_no_strobe", {31'd0, code_valid}, 32'h0);
    send_word(9'h1C7, -1, 0);
    send_word(9'h1C7, -1, 0);
    chk("realign_no_early_lock", {31'd0, locked}, 32'h0);
    send_word(9'h1C7, -1, 0);
    chk("realign_relock", {31'd0, locked}, 32'h1);
    push_exp(9'h055);
    send_word(9'h055, -1, 0);

    // Shifted sync-like stream causes a false hit before the true preamble.
    realign = 1'b1;
    idle(1);
    realign = 1'b0;
    e0 = err_cnt;
    send_word(9'h18E, -1, 0);
    send_word(9'h1C7, -1, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_word(9'h1C7, -1, 0);
    send_word(9'h1C7, -1, 0);
    send_word(9'h1C7, -1, 0);
    chk("false_lock_recovered", {31'd0, locked}, 32'h1);
    chk("false_lock_err_once", 32'(err_cnt - e0), 32'h1);
    push_exp(9'h0FF);
    send_word(9'h0FF, -1, 0);
    chk("cv_latency_0FF", {31'd0, code_valid}, 32'h1);

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
